// File: rtl/ppu_pkg.sv
// Shared state encoding, OAM layout constants and sprite record for the PPU sprite scan path.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_Y,
        CMP_Y,
        RD_X,
        RD_T,
        RD_A,
        FIN
    } scan_state_t;

    localparam logic [1:0] OFF_Y    = 2'd0;
    localparam logic [1:0] OFF_X    = 2'd1;
    localparam logic [1:0] OFF_TILE = 2'd2;
    localparam logic [1:0] OFF_ATTR = 2'd3;

    localparam logic [8:0] SPRITE_H_SHORT = 9'd8;
    localparam logic [8:0] SPRITE_H_TALL  = 9'd16;
    localparam logic [8:0] LINE_OFFSET    = 9'd16;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [5:0] oam_idx;
    } sprite_t;

    // Each OAM entry is 4 bytes, so {idx, off} is exactly 4*idx + off.
    function automatic logic [15:0] oam_byte_addr(input logic [15:0] base,
                                                  input logic [5:0]  idx,
                                                  input logic [1:0]  off);
        return base + {8'd0, idx, off};
    endfunction

endpackage

// File: rtl/ppu_sprite_buf.sv
// Per-line sprite buffer: slot storage, insert with shift-up, and zero-masked read mux.
// Define PPU_OAM_XSORT_EN to keep slots ordered by ascending X (stable); otherwise slots follow OAM order.
module ppu_sprite_buf
    import ppu_pkg::*;
#(
    parameter int MAX_SPRITES = 10,
    localparam int CW = $clog2(MAX_SPRITES + 1),
    localparam int SW = $clog2(MAX_SPRITES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count,
    input  logic          ins_en,
    input  logic [7:0]    ins_y,
    input  logic [7:0]    ins_x,
    input  logic [5:0]    ins_idx,
    input  logic          tile_we,
    input  logic          attr_we,
    input  logic [7:0]    wr_data,
    input  logic [SW-1:0] rd_sel,
    output sprite_t       rd_entry
);

    sprite_t       slots [MAX_SPRITES];
    logic [CW-1:0] ins_pos;
    logic [CW-1:0] pend_slot;

    always_comb begin
`ifdef PPU_OAM_XSORT_EN
        // Land after every stored sprite with X <= new X, so equal X keeps OAM order.
        ins_pos = '0;
        for (int i = 0; i < MAX_SPRITES; i++)
            if (CW'(i) < count && slots[i].x <= ins_x) ins_pos = CW'(i + 1);
`else
        ins_pos = count;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the slot array sits inside the reset branch on purpose; a reset buffer must read back as zeros.
            for (int i = 0; i < MAX_SPRITES; i++) slots[i] <= '0;
            pend_slot <= '0;
        end else if (ins_en) begin
            for (int i = 1; i < MAX_SPRITES; i++)
                if (CW'(i) > ins_pos && CW'(i) <= count) slots[i] <= slots[i-1];
            slots[ins_pos] <= '{y: ins_y, x: ins_x, tile: 8'd0, attr: 8'd0, oam_idx: ins_idx};
            pend_slot      <= ins_pos;
        end else begin
            if (tile_we) slots[pend_slot].tile <= wr_data;
            if (attr_we) slots[pend_slot].attr <= wr_data;
        end
    end

    always_comb begin
        rd_entry = '0;
        if (CW'(rd_sel) < count) rd_entry = slots[rd_sel];
    end

endmodule

// File: rtl/ppu_oam_scanner.sv
// OAM scanner: walks NUM_ENTRIES sprite entries for one scanline and collects up to MAX_SPRITES hits.
// Slot ordering is X-sorted when PPU_OAM_XSORT_EN is defined, OAM order otherwise.
module ppu_oam_scanner
    import ppu_pkg::*;
#(
    parameter int          NUM_ENTRIES = 40,
    parameter int          MAX_SPRITES = 10,
    parameter int          RD_LATENCY  = 1,
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    localparam int CW = $clog2(MAX_SPRITES + 1),
    localparam int SW = $clog2(MAX_SPRITES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    ly,
    input  logic          tall_mode,
    output logic          oam_rd,
    output logic [15:0]   oam_addr,
    input  logic [7:0]    oam_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic [SW-1:0] rd_sel,
    output logic [7:0]    rd_y,
    output logic [7:0]    rd_x,
    output logic [7:0]    rd_tile,
    output logic [7:0]    rd_attr,
    output logic [5:0]    rd_oam_idx
);

    scan_state_t state;
    logic [5:0]  entry;
    logic [2:0]  wait_cnt;
    logic [7:0]  ly_q;
    logic [7:0]  y_q;
    logic        tall_q;
    logic        cap, hit, room, fetch, advance, last_entry;
    logic [8:0]  line, y_ext, height;
    sprite_t     rd_entry;

    assign cap        = (wait_cnt == 3'(RD_LATENCY));
    assign last_entry = (entry == 6'(NUM_ENTRIES - 1));
    assign line       = {1'b0, ly_q} + LINE_OFFSET;
    assign y_ext      = {1'b0, y_q};
    assign height     = tall_q ? SPRITE_H_TALL : SPRITE_H_SHORT;
    assign hit        = (line >= y_ext) && (line < y_ext + height);
    assign room       = (count < CW'(MAX_SPRITES));
    assign fetch      = (state == CMP_Y) && hit && room;
    assign advance    = ((state == CMP_Y) && !fetch) || ((state == RD_A) && cap);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            entry    <= '0;
            wait_cnt <= '0;
            ly_q     <= '0;
            y_q      <= '0;
            tall_q   <= 1'b0;
            oam_rd   <= 1'b0;
            oam_addr <= OAM_BASE;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // NOTE: strobes default low here and are raised only by the branch issuing them, keeping them one cycle wide.
            oam_rd <= 1'b0;
            done   <= 1'b0;
            if (start) begin
                // A start mid-scan simply restarts; the aborted scan never reaches FIN.
                state    <= RD_Y;
                entry    <= '0;
                wait_cnt <= '0;
                ly_q     <= ly;
                tall_q   <= tall_mode;
                count    <= '0;
                overflow <= 1'b0;
                busy     <= 1'b1;
                oam_rd   <= 1'b1;
                oam_addr <= oam_byte_addr(OAM_BASE, 6'd0, OFF_Y);
            end else begin
                case (state)
                    IDLE: ;
                    RD_Y, RD_X, RD_T, RD_A: begin
                        if (!cap) begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end else begin
                            wait_cnt <= '0;
                            case (state)
                                RD_Y: begin
                                    y_q   <= oam_data;
                                    state <= CMP_Y;
                                end
                                RD_X: begin
                                    state    <= RD_T;
                                    oam_rd   <= 1'b1;
                                    oam_addr <= oam_byte_addr(OAM_BASE, entry, OFF_TILE);
                                end
                                RD_T: begin
                                    state    <= RD_A;
                                    oam_rd   <= 1'b1;
                                    oam_addr <= oam_byte_addr(OAM_BASE, entry, OFF_ATTR);
                                end
                                default: count <= count + CW'(1);
                            endcase
                        end
                    end
                    CMP_Y: begin
                        if (fetch) begin
                            state    <= RD_X;
                            wait_cnt <= '0;
                            oam_rd   <= 1'b1;
                            oam_addr <= oam_byte_addr(OAM_BASE, entry, OFF_X);
                        end else if (hit) begin
                            overflow <= 1'b1;
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase

                if (advance) begin
                    wait_cnt <= '0;
                    if (last_entry) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        entry    <= entry + 6'd1;
                        state    <= RD_Y;
                        oam_rd   <= 1'b1;
                        oam_addr <= oam_byte_addr(OAM_BASE, entry + 6'd1, OFF_Y);
                    end
                end
            end
        end
    end

    ppu_sprite_buf #(.MAX_SPRITES(MAX_SPRITES)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .ins_en   ((state == RD_X) && cap),
        .ins_y    (y_q),
        .ins_x    (oam_data),
        .ins_idx  (entry),
        .tile_we  ((state == RD_T) && cap),
        .attr_we  ((state == RD_A) && cap),
        .wr_data  (oam_data),
        .rd_sel   (rd_sel),
        .rd_entry (rd_entry)
    );

    assign rd_y       = rd_entry.y;
    assign rd_x       = rd_entry.x;
    assign rd_tile    = rd_entry.tile;
    assign rd_attr    = rd_entry.attr;
    assign rd_oam_idx = rd_entry.oam_idx;

endmodule

// File: doc/ppu_oam_scanner.md
PPU_OAM_SCANNER -- requirements
Module: ppu_oam_scanner

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 40, meaning OAM entries scanned per line (4 bytes each).
REQ-002 SHALL have parameter MAX_SPRITES, default 10, meaning sprite buffer depth per line.
REQ-003 SHALL have parameter RD_LATENCY, default 1, meaning cycles from oam_rd/oam_addr to valid oam_data (range 1-4).
REQ-004 SHALL have parameter OAM_BASE, default 16'hFE00, meaning byte address of entry 0.
REQ-005 SHALL have a single clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that begins a scan for line ly.
REQ-009 ly  input  8  current scanline, sampled at start.
REQ-010 tall_mode  input  1  0 = 8-line sprites, 1 = 16-line sprites (LCDC[2]), sampled at start.
REQ-011 oam_rd  output  1  OAM read strobe.
REQ-012 oam_addr  output  16  OAM byte address.
REQ-013 oam_data  input  8  OAM read data, valid RD_LATENCY cycles after oam_rd.
REQ-014 busy  output  1  high from the cycle after start until done.
REQ-015 done  output  1  one-cycle pulse at scan completion.
REQ-016 count  output  $clog2(MAX_SPRITES+1)  sprites stored.
REQ-017 overflow  output  1  more than MAX_SPRITES entries matched.
REQ-018 rd_sel  input  $clog2(MAX_SPRITES)  buffer slot select.
REQ-019 rd_y, rd_x, rd_tile, rd_attr  output  8 each  slot bytes, combinational from rd_sel.
REQ-020 rd_oam_idx  output  6  OAM entry number of the selected slot.

Function
REQ-021 SHALL implement states IDLE, RD_Y, CMP_Y, RD_X, RD_T, RD_A, FIN.
REQ-022 IDLE -> RD_Y on start; latch ly and tall_mode; clear count and overflow; set entry index to 0.
REQ-023 Each RD_* state SHALL assert oam_rd for one cycle at OAM_BASE + 4*entry + byte offset (Y=0, X=1, tile=2, attr=3), then wait RD_LATENCY cycles before capturing oam_data.
REQ-024 CMP_Y SHALL compute the hit in 9-bit arithmetic: (ly+16 >= y) && (ly+16 < y + (tall_mode ? 16 : 8)).
REQ-025 Hit with count < MAX_SPRITES -> RD_X -> RD_T -> RD_A; count increments when attr is captured.
REQ-026 Hit with count == MAX_SPRITES SHALL set overflow and fetch no further bytes for that entry.
REQ-027 Miss, or completion of RD_A, SHALL advance to the next entry (RD_Y); after entry NUM_ENTRIES-1 -> FIN.
REQ-028 FIN SHALL pulse done for one cycle and return to IDLE; count, overflow and buffer hold until the next start.
REQ-029 start while busy SHALL abort the scan and restart at entry 0 on the next cycle; no done pulse for the aborted scan.
REQ-030 rd_sel >= count SHALL return all-zero rd_* outputs.
REQ-031 oam_rd SHALL be low in IDLE and FIN.

Reset
REQ-032 Reset SHALL force IDLE, busy=0, done=0, oam_rd=0, oam_addr=OAM_BASE, count=0, overflow=0, and clear all buffer slots to zero.
REQ-033 Reset asserted mid-scan SHALL take effect immediately, with no done pulse.

Configuration
REQ-034 With macro PPU_OAM_XSORT_EN defined, the buffer SHALL stay sorted by ascending X: the slot is chosen when X is captured, later slots shift up, and ties keep OAM order.
REQ-035 Without PPU_OAM_XSORT_EN, the buffer SHALL be in OAM order (slot = count at hit).

Structure
REQ-036 A shared package ppu_pkg SHALL hold the scanner state enum, OAM byte-offset constants, and the sprite-height constants 8 and 16.
REQ-037 A sub-module ppu_sprite_buf (slot storage, insert/shift, read mux) SHALL be used.

Verification
REQ-038 Entry 0 at Y=16 and X=8, ly=0, tall_mode=0 -> count=1; slot0 = (16, 8, tile, attr); rd_oam_idx=0; done pulses.
REQ-039 Twelve entries at Y=20, ly=10 -> count=10, overflow=1; slots hold OAM entries 0-9.
REQ-040 Y=10, ly=9: tall_mode=0 -> miss; tall_mode=1 -> hit.
REQ-041 Second start 30 cycles into a scan -> no done for the first scan; results match the second scan only.
REQ-042 With PPU_OAM_XSORT_EN, hits at X=50, 20, 20 (entries 0, 1, 2) -> slot order: entries 1, 2, 0.
REQ-043 RD_LATENCY=3 with ly=200 (no hits) -> 40 Y reads only, done pulses, count=0.
